xbar_out_arbiter: RTL and testbench

Per-output-port switch allocator for the 5-port NOC crossbar. Each router instantiates five of these, one per output (N, S, W, E, L). Each arbiter chooses one requesting input with round-robin fairness and drives the 3-bit select code into that output's 5:1 data mux. It holds the grant from the head flit through the tail flit, so packets are never interleaved on an output.

---
 rtl/xbar_out_arbiter.sv | 107 ++++++++++
 tb/tb_xbar_out_arbiter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/xbar_out_arbiter.sv
// xbar_out_arbiter: round-robin switch allocator for one crossbar output.
// It locks the winning input from the head flit to the tail flit, so packets
// are never interleaved on this output.
//
// Ports:
//   clk_i        clock, all state updates on the rising edge
//   rst_i        synchronous active-high reset
//   req_i[4:0]   per-input request (bit0 N, bit1 S, bit2 W, bit3 E, bit4 L)
//   tail_i[4:0]  per-input tail marker, same bit order
//   out_ready_i  downstream can accept a flit this cycle
//   sel_o[2:0]   mux select code of the granted input (holds while idle)
//   grant_o[4:0] one-hot grant, zero while idle
//   valid_o      granted input presents a flit (combinational)
//   xfer_o       flit moves this cycle (combinational)
module xbar_out_arbiter (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [4:0] req_i,
    input  logic [4:0] tail_i,
    input  logic       out_ready_i,
    output logic [2:0] sel_o,
    output logic [4:0] grant_o,
    output logic       valid_o,
    output logic       xfer_o
);

    localparam int unsigned NUM_PORTS = 5;
    localparam int unsigned IDX_W     = 3;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_sel;
    logic [4:0]         r_grant;

    logic               w_found;
    logic [IDX_W-1:0]   w_pick;
    logic               w_valid;
    logic               w_xfer;
    logic               w_tail_xfer;

    // First requester scanning from r_ptr upward with wrap at NUM_PORTS.
    always_comb begin
        logic [IDX_W:0] v_idx;
        w_found = 1'b0;
        w_pick  = '0;
        v_idx   = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            v_idx = {1'b0, r_ptr} + (IDX_W+1)'(k);
            if (v_idx >= (IDX_W+1)'(NUM_PORTS)) begin
                v_idx = v_idx - (IDX_W+1)'(NUM_PORTS);
            end
            if (!w_found && req_i[v_idx[IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_pick  = v_idx[IDX_W-1:0];
            end
        end
    end

    // r_grant is zero whenever the arbiter is idle, so masking suffices.
    assign w_valid     = (r_state == LOCKED) && ((req_i & r_grant) != 5'b0);
    assign w_xfer      = w_valid && out_ready_i;
    assign w_tail_xfer = w_xfer && ((tail_i & r_grant) != 5'b0);

    // Lock / release state machine with round-robin pointer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_sel   <= '0;
            r_grant <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state <= LOCKED;
                        r_sel   <= w_pick;
                        r_grant <= 5'(5'b00001 << w_pick);
                    end
                end
                LOCKED: begin
                    // Pointer advances only when a packet completes.
                    if (w_tail_xfer) begin
                        r_state <= IDLE;
                        r_grant <= '0;
                        r_ptr   <= (r_sel == IDX_W'(NUM_PORTS - 1)) ? '0
                                                                    : r_sel + IDX_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

    assign sel_o   = r_sel;
    assign grant_o = r_grant;
    assign valid_o = w_valid;
    assign xfer_o  = w_xfer;

endmodule

// File: tb/tb_xbar_out_arbiter.sv
// Self-checking bench for xbar_out_arbiter: directed scenarios followed by a
// random phase, all compared against a packet-level reference model.
module tb_xbar_out_arbiter;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [4:0] req_i;
    logic [4:0] tail_i;
    logic       out_ready_i;
    logic [2:0] sel_o;
    logic [4:0] grant_o;
    logic       valid_o;
    logic       xfer_o;

    int total = 0;
    int bad   = 0;

    // Reference model: lock flag, owner, round-robin pointer, last select.
    bit m_known  = 1'b0;
    bit m_locked = 1'b0;
    int m_g      = 0;
    int m_ptr    = 0;
    int m_sel    = 0;
    bit last_xfer = 1'b0;
    int last_g    = 0;
    int wcnt;

    xbar_out_arbiter dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (req_i),
        .tail_i      (tail_i),
        .out_ready_i (out_ready_i),
        .sel_o       (sel_o),
        .grant_o     (grant_o),
        .valid_o     (valid_o),
        .xfer_o      (xfer_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int first_req(input logic [4:0] rq, input int ptr);
        for (int k = 0; k < 5; k++) begin
            if (rq[(ptr + k) % 5]) return (ptr + k) % 5;
        end
        return -1;
    endfunction

    // One clock: drive inputs, compare at the falling edge, advance the model.
    task automatic step(input logic r, input logic [4:0] rq, input logic [4:0] tl,
                        input logic rd);
        logic [4:0] e_grant;
        logic       e_valid;
        logic       e_xfer;
        int         pick;
        rst_i       = r;
        req_i       = rq;
        tail_i      = tl;
        out_ready_i = rd;
        @(negedge clk_i);
        e_grant = m_locked ? 5'(1 << m_g) : 5'b0;
        e_valid = m_locked && rq[m_g];
        e_xfer  = e_valid && rd;
        if (m_known) begin
            chk("grant", 8'(grant_o), 8'(e_grant));
            chk("sel",   8'(sel_o),   8'(m_sel));
            chk("valid", 8'(valid_o), 8'(e_valid));
            chk("xfer",  8'(xfer_o),  8'(e_xfer));
        end
        last_xfer = e_xfer;
        last_g    = m_g;
        if (r) begin
            m_known  = 1'b1;
            m_locked = 1'b0;
            m_ptr    = 0;
            m_sel    = 0;
        end else if (!m_locked) begin
            pick = first_req(rq, m_ptr);
            if (pick >= 0) begin
                m_locked = 1'b1;
                m_g      = pick;
                m_sel    = pick;
            end
        end else if (e_xfer && tl[m_g]) begin
            m_locked = 1'b0;
            m_ptr    = (m_g + 1) % 5;
        end
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        // Reset with every input requesting.
        step(1'b1, 5'b11111, 5'b11111, 1'b1);
        step(1'b1, 5'b11111, 5'b11111, 1'b1);
        step(1'b0, 5'b11111, 5'b11111, 1'b1);
        chk("reset_first_grant", 8'(grant_o), 8'h01);
        chk("reset_first_sel",   8'(sel_o),   8'h00);

        // Round robin: single-flit packets from everyone.
        for (int c = 0; c < 12; c++) step(1'b0, 5'b11111, 5'b11111, 1'b1);

        // Packet lock: W sends 4 flits while E and L keep requesting.
        step(1'b1, 5'b00000, 5'b00000, 1'b1);
        step(1'b0, 5'b00100, 5'b00000, 1'b1);
        wcnt = 0;
        for (int c = 0; c < 20 && wcnt < 4; c++) begin
            step(1'b0, 5'b11100, (wcnt == 3) ? 5'b00100 : 5'b00000, 1'b1);
            if (last_xfer && last_g == 2) wcnt++;
        end
        chk("w_flits", 8'(wcnt), 8'd4);
        chk("w_release_idle", 8'(grant_o), 8'h00);
        step(1'b0, 5'b11000, 5'b00000, 1'b1);
        chk("e_after_w_grant", 8'(grant_o), 8'h08);
        chk("e_after_w_sel",   8'(sel_o),   8'h03);

        // Backpressure and bubble while S owns the output.
        step(1'b1, 5'b00000, 5'b00000, 1'b1);
        step(1'b0, 5'b00010, 5'b00000, 1'b1);
        for (int c = 0; c < 3; c++) step(1'b0, 5'b11111, 5'b00000, 1'b0);
        for (int c = 0; c < 2; c++) step(1'b0, 5'b11101, 5'b00000, 1'b1);
        chk("bubble_hold_grant", 8'(grant_o), 8'h02);
        chk("bubble_hold_sel",   8'(sel_o),   8'h01);
        step(1'b0, 5'b11111, 5'b00010, 1'b1);
        step(1'b0, 5'b00000, 5'b00000, 1'b1);

        // Pointer wrap after L completes.
        step(1'b1, 5'b00000, 5'b00000, 1'b1);
        step(1'b0, 5'b10000, 5'b10000, 1'b1);
        step(1'b0, 5'b10000, 5'b10000, 1'b1);
        step(1'b0, 5'b10011, 5'b10011, 1'b1);
        chk("wrap_grant_n", 8'(grant_o), 8'h01);
        for (int c = 0; c < 6; c++) step(1'b0, 5'b10011, 5'b10011, 1'b1);

        // Reset while E is locked with ptr at 3.
        step(1'b1, 5'b00000, 5'b00000, 1'b1);
        step(1'b0, 5'b00100, 5'b00100, 1'b1);
        step(1'b0, 5'b00100, 5'b00100, 1'b1);
        step(1'b0, 5'b01010, 5'b00000, 1'b1);
        chk("lock_e", 8'(grant_o), 8'h08);
        step(1'b0, 5'b01010, 5'b00000, 1'b1);
        step(1'b1, 5'b01010, 5'b00000, 1'b1);
        chk("midrst_grant", 8'(grant_o), 8'h00);
        chk("midrst_sel",   8'(sel_o),   8'h00);
        step(1'b0, 5'b01010, 5'b00000, 1'b1);
        chk("midrst_next_grant", 8'(grant_o), 8'h02);

        // Random traffic, sparse tails for multi-flit packets, rare resets.
        for (int c = 0; c < 600; c++) begin
            step(($urandom_range(0, 59) == 0),
                 5'($urandom),
                 5'($urandom & $urandom),
                 ($urandom_range(0, 3) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
